// File: rtl/ac_port_driver.sv
// Command-port driver for an accumulator: turns WRITE/CLEAR/READ commands into
// single-cycle strobes or a timed read, and returns read data on a response handshake.
module ac_port_driver #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [9:0] cmd_data,
  output logic [9:0] ac_in1,
  output logic       ac_we,
  output logic       ac_re,
  output logic       ac_clear,
  input  logic [9:0] ac_out1,
  output logic       rsp_valid,
  output logic [9:0] rsp_data,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    CLR  = 3'd2,
    RD   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  // Counter is loaded with READ_LAT-1 so RD lasts exactly READ_LAT cycles.
  localparam logic [1:0] LAT_M1   = 2'(READ_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [9:0] ac_in1_q, ac_in1_d;
  logic [9:0] rsp_data_q, rsp_data_d;
  logic       accept;

  assign accept = cmd_valid && (state_q == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: state_d = WR;
            OP_READ:  state_d = RD;
            OP_CLEAR: state_d = CLR;
            OP_NOP:   state_d = IDLE;
            default:  state_d = IDLE;
          endcase
        end
      end
      WR:      state_d = IDLE;
      CLR:     state_d = IDLE;
      RD:      if (cnt_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ac_in1_d   = ac_in1_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    if (accept && cmd_op == OP_WRITE) ac_in1_d = cmd_data;
    if (accept && cmd_op == OP_READ)  cnt_d    = LAT_M1;
    if (state_q == RD) begin
      if (cnt_q == 2'd0) begin
        rsp_data_d = ac_out1;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      ac_in1_q   <= 10'd0;
      rsp_data_q <= 10'd0;
    end else begin
      cnt_q      <= cnt_d;
      ac_in1_q   <= ac_in1_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    cmd_ready = (state_q == IDLE) && !rst;
    ac_we     = (state_q == WR);
    ac_clear  = (state_q == CLR);
    ac_re     = (state_q == RD);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    ac_in1    = ac_in1_q;
    rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_ac_port_driver.sv
// Scoreboard bench for ac_port_driver with READ_LAT=3 and a simple accumulator model.
module tb_ac_port_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [9:0] cmd_data = 10'd0;
  logic [9:0] ac_in1;
  logic       ac_we, ac_re, ac_clear;
  logic [9:0] ac_out1;
  logic       rsp_valid;
  logic [9:0] rsp_data;
  logic       rsp_ready = 1'b1;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [9:0] rsp_q[$];
  logic [9:0] wr_q[$];
  int         clr_exp = 0;
  logic [9:0] acc = 10'd0;

  always #5 clk = ~clk;

  ac_port_driver #(.READ_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ac_in1(ac_in1), .ac_we(ac_we), .ac_re(ac_re), .ac_clear(ac_clear), .ac_out1(ac_out1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  // Accumulator model: latches writes, zeroes on clear.
  always @(posedge clk) begin
    if (ac_clear) acc <= 10'd0;
    else if (ac_we) acc <= ac_in1;
    cyc <= cyc + 1;
  end
  assign ac_out1 = acc;

  function automatic void chk(input bit ok, input string name, input int act, input int exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  // Monitor: strobe events, read-enable run length and responses.
  logic [9:0] last_wr = 10'd0;
  int         re_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_wr = 10'd0;
      re_run  = 0;
    end else begin
      chk(cmd_ready == !busy, "cmd_ready_vs_busy", cmd_ready, !busy);
      if (ac_we || ac_re || ac_clear)
        chk((int'(ac_we) + int'(ac_re) + int'(ac_clear)) == 1, "strobe_onehot",
            {ac_we, ac_re, ac_clear}, 1);
      if (ac_we) begin
        if (wr_q.size() == 0) chk(1'b0, "unexpected_write", ac_in1, 0);
        else begin
          chk(ac_in1 == wr_q[0], "write_data", ac_in1, wr_q[0]);
          last_wr = wr_q.pop_front();
        end
      end else begin
        chk(ac_in1 == last_wr, "ac_in1_hold", ac_in1, last_wr);
      end
      if (ac_clear) begin
        chk(clr_exp > 0, "unexpected_clear", clr_exp, 1);
        if (clr_exp > 0) clr_exp--;
      end
      if (ac_re) re_run++;
      else if (re_run > 0) begin
        chk(re_run == 3, "re_cycles", re_run, 3);
        re_run = 0;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk(1'b0, "unexpected_rsp", rsp_data, 0);
        else begin
          chk(rsp_data == rsp_q[0], "rsp_data", rsp_data, rsp_q[0]);
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
    end
  end

  // Present a command and return the cycle on which it was accepted; cmd_valid stays high.
  task automatic send(input logic [1:0] op, input logic [9:0] d, output int acc_cyc);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) chk(1'b0, "accept_timeout", n, 50);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk(1'b0, "rsp_timeout", n, 20);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({cmd_ready, ac_we, ac_re, ac_clear, rsp_valid, busy} == 6'b0, {tag, "_ctl"},
        {cmd_ready, ac_we, ac_re, ac_clear, rsp_valid, busy}, 0);
    chk(ac_in1 == 10'd0, {tag, "_ac_in1"}, ac_in1, 0);
    chk(rsp_data == 10'd0, {tag, "_rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    int r, a0, a1, a2;
    #12;
    check_reset_vals("reset_init");

    // First command on the first edge after reset release.
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    wr_q.push_back(10'h2A5);
    send(2'b01, 10'h2A5, a0);
    cmd_valid = 1'b0;
    chk(a0 == r + 1, "first_accept_cycle", a0 - r, 1);
    chk(ac_we == 1'b1 && ac_in1 == 10'h2A5, "write_2a5", ac_in1, 10'h2A5);
    idle_cycles(3);
    chk(ac_in1 == 10'h2A5 && !ac_we, "ac_in1_after_wr", ac_in1, 10'h2A5);

    // READ with response stalled for five cycles.
    wr_q.push_back(10'h155);
    send(2'b01, 10'h155, a0);
    rsp_ready = 1'b0;
    rsp_q.push_back(10'h155);
    send(2'b10, 10'h000, a0);
    cmd_valid = 1'b0;
    wait_rsp();
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk(rsp_valid == 1'b1 && rsp_data == 10'h155, "rsp_stalled", rsp_data, 10'h155);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk(!rsp_valid && !busy, "rsp_done_idle", {rsp_valid, busy}, 0);

    // CLEAR then READ returns zero.
    clr_exp++;
    send(2'b11, 10'h000, a0);
    chk(ac_clear == 1'b1 && ac_in1 == 10'h155, "clear_strobe", ac_in1, 10'h155);
    rsp_q.push_back(10'h000);
    send(2'b10, 10'h000, a0);
    cmd_valid = 1'b0;
    wait_rsp();
    idle_cycles(2);
    chk(rsp_data == 10'h000 && !rsp_valid, "rsp_after_clear", rsp_data, 0);

    // Back-to-back with cmd_valid held high.
    wr_q.push_back(10'h001);
    wr_q.push_back(10'h3FF);
    rsp_q.push_back(10'h3FF);
    send(2'b01, 10'h001, a0);
    send(2'b01, 10'h3FF, a1);
    send(2'b10, 10'h000, a2);
    cmd_valid = 1'b0;
    chk(a1 - a0 == 2, "b2b_wr_spacing", a1 - a0, 2);
    chk(a2 - a1 == 2, "b2b_rd_spacing", a2 - a1, 2);
    wait_rsp();
    idle_cycles(2);
    chk(rsp_data == 10'h3FF, "rsp_data_retained", rsp_data, 10'h3FF);

    // Asynchronous reset in the middle of a WR cycle.
    send(2'b01, 10'h0AA, a0);
    cmd_valid = 1'b0;
    chk(ac_we == 1'b1, "wr_before_rst", ac_we, 1);
    #1 rst = 1'b1;
    #1 check_reset_vals("reset_mid_wr");
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);

    // Reset during RESP discards the response; then a NOP.
    rsp_ready = 1'b0;
    rsp_q.push_back(10'h3FF);
    send(2'b10, 10'h000, a0);
    cmd_valid = 1'b0;
    wait_rsp();
    #2 rst = 1'b1;
    rsp_q.delete();
    #1 check_reset_vals("reset_mid_resp");
    rsp_ready = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(5);
    send(2'b00, 10'h123, a0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({ac_we, ac_re, ac_clear} == 3'b0 && cmd_ready, "nop_quiet",
          {cmd_ready, ac_we, ac_re, ac_clear}, 4'b1000);
    end

    idle_cycles(2);
    chk(rsp_q.size() == 0, "rsp_queue_empty", rsp_q.size(), 0);
    chk(wr_q.size() == 0 && clr_exp == 0, "strobe_queue_empty", wr_q.size() + clr_exp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
